// File: rtl/buffer_reader.sv
// Read side of the UART receive ring buffer: fetches each newly written byte from the
// buffer RAM read port and offers it to the Morse encoder on a valid/ready handshake.
module buffer_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_w,
    output logic [ADDR_W-1:0] address_r,
    output logic              rd_en,
    input  logic [DATA_W-1:0] data_r,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] level,
    output logic              empty,
    output logic              overrun
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] address_w_q;
    logic [ADDR_W-1:0] addr_r_q, addr_r_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              data_ok;
    logic              lap;

    assign level   = address_w - rd_ptr_q;
    assign empty   = (level == '0);
    // Writer moved this cycle and landed on the byte we last fetched: it has lapped us.
    assign lap     = (address_w != address_w_q) && (address_w == rd_ptr_q);
    // cnt_q counts FETCH cycles from the rd_en cycle; data_r is valid when it reaches the latency.
    assign data_ok = (cnt_q == LAT_CNT);

    assign address_r = addr_r_q;
    assign rd_en     = rd_en_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            address_w_q <= '0;
            addr_r_q    <= '0;
            rd_en_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            address_w_q <= address_w;
            addr_r_q    <= addr_r_d;
            rd_en_q     <= rd_en_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!empty) state_d = FETCH;
                FETCH:   if (data_ok) state_d = HOLD;
                HOLD:    if (tx_valid_q && tx_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        addr_r_d   = addr_r_q;
        rd_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = overrun_q | lap;
        cnt_d      = cnt_q;
        if (flush) begin
            // Pre-edge address_w: a byte written in this same cycle is still read later.
            rd_ptr_d   = address_w;
            tx_valid_d = 1'b0;
            overrun_d  = 1'b0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        addr_r_d = rd_ptr_q + 1'b1;
                        rd_en_d  = 1'b1;
                        cnt_d    = '0;
                    end
                end
                FETCH: begin
                    if (data_ok) begin
                        tx_data_d  = data_r;
                        tx_valid_d = 1'b1;
                        rd_ptr_d   = addr_r_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (tx_ready) tx_valid_d = 1'b0;
                end
                default: begin
                    tx_valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader: a latency-1 and a latency-3 instance share the writer
// stimulus; a transaction-level model per instance is compared every cycle.
module tb_buffer_reader;

    logic       clk = 1'b0;
    logic       rst, flush, tx_ready;
    logic [9:0] aw;

    logic [9:0] address_r1, level1, address_r3, level3;
    logic       rd_en1, tx_valid1, empty1, overrun1;
    logic       rd_en3, tx_valid3, empty3, overrun3;
    logic [7:0] data_r1, tx_data1, data_r3, tx_data3;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    buffer_reader #(.ADDR_W(10), .DATA_W(8), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .address_w(aw), .address_r(address_r1), .rd_en(rd_en1),
        .data_r(data_r1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .flush(flush), .level(level1), .empty(empty1), .overrun(overrun1));

    buffer_reader #(.ADDR_W(10), .DATA_W(8), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .address_w(aw), .address_r(address_r3), .rd_en(rd_en3),
        .data_r(data_r3), .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready),
        .flush(flush), .level(level3), .empty(empty3), .overrun(overrun3));

    function automatic logic [7:0] ram_f(input logic [9:0] a);
        int v;
        v = int'(a) * 7 + 58;
        return 8'(v);
    endfunction

    // Buffer RAM read ports; 8'hEE marks cycles where data_r is not valid.
    logic [7:0] p1;
    logic [7:0] p3 [3];
    assign data_r1 = p1;
    assign data_r3 = p3[2];
    always @(posedge clk) begin
        p1    <= rd_en1 ? ram_f(address_r1) : 8'hEE;
        p3[0] <= rd_en3 ? ram_f(address_r3) : 8'hEE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    typedef struct {
        logic [9:0] ptr, aw_q, addr;
        logic [7:0] data;
        bit busy, rden, valid, ovr;
        int age;
    } m_t;
    m_t m [2];

    task automatic model_step(input int k, input int lat);
        if (rst) begin
            m[k] = '{ptr: 10'd0, aw_q: 10'd0, addr: 10'd0, data: 8'd0,
                     busy: 1'b0, rden: 1'b0, valid: 1'b0, ovr: 1'b0, age: 0};
            return;
        end
        m[k].rden = 1'b0;
        if (flush) begin
            m[k].ptr = aw; m[k].valid = 1'b0; m[k].ovr = 1'b0; m[k].busy = 1'b0;
        end else begin
            if (aw != m[k].aw_q && aw == m[k].ptr) m[k].ovr = 1'b1;
            if (m[k].busy) begin
                if (m[k].age == lat) begin
                    m[k].valid = 1'b1; m[k].data = ram_f(m[k].addr);
                    m[k].ptr = m[k].addr; m[k].busy = 1'b0;
                end else m[k].age++;
            end else if (m[k].valid) begin
                if (tx_ready) m[k].valid = 1'b0;
            end else if (aw != m[k].ptr) begin
                m[k].busy = 1'b1; m[k].age = 0; m[k].addr = m[k].ptr + 10'd1; m[k].rden = 1'b1;
            end
        end
        m[k].aw_q = aw;
    endtask

    always @(posedge clk) begin
        model_step(0, 1);
        model_step(1, 3);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_exp(input int k);
        logic [9:0] lv;
        lv = aw - m[k].ptr;
        return 64'({m[k].addr, m[k].rden, m[k].data, m[k].valid, lv, (lv == 10'd0), m[k].ovr});
    endfunction

    logic [9:0] rdq1 [$];
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_lat1", 64'({address_r1, rd_en1, tx_data1, tx_valid1, level1, empty1, overrun1}),
                pack_exp(0));
            chk("model_lat3", 64'({address_r3, rd_en3, tx_data3, tx_valid3, level3, empty3, overrun3}),
                pack_exp(1));
            if (rd_en1) rdq1.push_back(address_r1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; flush = 1'b0; tx_ready = 1'b0; aw = 10'd0;
        @(posedge clk); #1; chk_en = 1'b1;
        step();
        @(negedge clk);
        chk("reset_outputs", 64'({address_r1, rd_en1, tx_data1, tx_valid1, level1, empty1, overrun1}),
            64'({10'd0, 1'b0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0}));

        // single byte, encoder not ready
        step(); rst = 1'b0;
        step(); aw = 10'd1;
        @(negedge clk); chk("empty_falls", 64'(empty1), 64'd0);
        step(); @(negedge clk); chk("rd_en_addr1", 64'({rd_en1, address_r1}), 64'({1'b1, 10'd1}));
        step(); @(negedge clk); chk("valid_not_yet", 64'(tx_valid1), 64'd0);
        step(); @(negedge clk); chk("byte_41", 64'({tx_valid1, tx_data1}), 64'({1'b1, 8'h41}));
        step(); @(negedge clk); chk("lat3_not_yet", 64'(tx_valid3), 64'd0);
        step(); @(negedge clk); chk("lat3_byte_41", 64'({tx_valid3, tx_data3}), 64'({1'b1, 8'h41}));
        repeat (6) step();
        @(negedge clk); chk("hold_stable", 64'({tx_valid1, tx_data1}), 64'({1'b1, 8'h41}));
        step(); tx_ready = 1'b1;
        step(); @(negedge clk); chk("accept_empty", 64'({tx_valid1, empty1}), 64'({1'b0, 1'b1}));

        // wrap through 3FF -> 000
        step(); flush = 1'b1; aw = 10'h3FE; rdq1.delete();
        step(); flush = 1'b0; aw = 10'h3FF;
        step(); aw = 10'h000;
        @(negedge clk); chk("wrap_level2", 64'(level1), 64'd2);
        repeat (20) step();
        @(negedge clk);
        chk("wrap_count", 64'(rdq1.size()), 64'd2);
        if (rdq1.size() == 2) begin
            chk("wrap_addr0", 64'(rdq1[0]), 64'h3FF);
            chk("wrap_addr1", 64'(rdq1[1]), 64'h000);
        end
        chk("wrap_level0", 64'({level1, empty1}), 64'({10'd0, 1'b1}));

        // overrun: writer laps the held read pointer
        tx_ready = 1'b0;
        for (int i = 1; i <= 1025; i++) begin
            step(); aw = 10'(i);
            if (i == 1024) begin
                @(negedge clk); chk("ovr_before_lap", 64'(overrun1), 64'd0);
            end
        end
        step(); @(negedge clk); chk("ovr_set", 64'({overrun1, overrun3}), 64'({1'b1, 1'b1}));
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk);
        chk("ovr_flush", 64'({overrun1, empty1, tx_valid1}), 64'({1'b0, 1'b1, 1'b0}));

        // reset during the rd_en cycle drops the in-flight byte
        tx_ready = 1'b1;
        step(); aw = 10'd2;
        step(); rst = 1'b1; aw = 10'd0;
        @(negedge clk); chk("rst_in_fetch_rden", 64'(rd_en1), 64'd1);
        step(); rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            step(); @(negedge clk);
            if (tx_valid1 || tx_valid3) seen = 1'b1;
        end
        chk("rst_no_valid", 64'(seen), 64'd0);
        chk("rst_idle_level", 64'({level1, empty1}), 64'({10'd0, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
